alu_stage: RTL and testbench

- Execution stage directly downstream of the register file.
- Operand A is driven by the register file's O1 output and operand B by its O2 output.
- Produces a registered 8-bit result, which is fed back to the register file's load input `i`, plus a registered flag set {Z,C,N,O}.
- Most operations complete in one cycle. MUL is an 8-cycle shift-add sequence under a start/busy/done handshake.

---
 rtl/alu_stage.sv | 193 +++++++++++++++++++
 tb/tb_alu_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// Execution stage behind the register file: single-cycle ALU operations plus an
// iterative unsigned shift-add multiplier, with registered result and {Z,C,N,O} flags.
module alu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       fun_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_A   = 4'h0, OP_B,   OP_NOT_A, OP_NOT_B,
    OP_ADD,        OP_ADC, OP_SUB,   OP_AND,
    OP_OR,         OP_XOR, OP_LSL,   OP_LSR,
    OP_ASR,        OP_CSL, OP_CSR,   OP_MUL
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic o;
  } flags_t;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  flags_t               flags_q, flags_d;
  logic                 done_q, done_d;

  op_e                  op;
  logic                 sub_sel;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_o;
  logic [2*WIDTH-1:0]   mul_sum;
  logic                 mul_last;

  assign op = op_e'(fun_sel);

  // Subtraction reuses the adder as A + ~B + 1, so C=1 means no borrow.
  assign sub_sel = (op == OP_SUB);
  assign add_b   = sub_sel ? ~b : b;
  assign add_cin = sub_sel | ((op == OP_ADC) & flags_q.c);
  assign add_sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = flags_q.c;
    alu_o   = flags_q.o;
    case (op)
      OP_A:     alu_res = a;
      OP_B:     alu_res = b;
      OP_NOT_A: alu_res = ~a;
      OP_NOT_B: alu_res = ~b;
      OP_ADD, OP_ADC, OP_SUB: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_o   = (a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_LSL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_LSR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_ASR: begin
        alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_CSL: begin
        alu_res = {a[WIDTH-2:0], flags_q.c};
        alu_c   = a[WIDTH-1];
      end
      OP_CSR: begin
        alu_res = {flags_q.c, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      default:  alu_res = '0;
    endcase
  end

  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d.z   = (alu_res == '0);
            flags_d.c   = alu_c;
            flags_d.n   = alu_res[WIDTH-1];
            flags_d.o   = alu_o;
            done_d      = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (mul_last) begin
          result_d    = mul_sum[WIDTH-1:0];
          result_hi_d = mul_sum[2*WIDTH-1:WIDTH];
          flags_d.z   = (mul_sum == '0);
          flags_d.c   = (mul_sum[2*WIDTH-1:WIDTH] != '0);
          flags_d.n   = mul_sum[2*WIDTH-1];
          flags_d.o   = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed vectors, randomized operations and
// multiplies against an arithmetic reference model, busy/done protocol and async reset.
module tb_alu_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] fun_sel;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the stage should currently present.
  logic [7:0] m_res;
  logic [7:0] m_hi;
  logic [3:0] m_flags;

  alu_stage #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fun_sel   (fun_sel),
    .a         (a),
    .b         (b),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model built from plain integer arithmetic and signed ranges.
  task automatic model_op(input int op, input int x, input int y);
    int r, s, sa, sb, ss, c, o, z, n, hi, p;
    c  = int'(m_flags[2]);
    o  = int'(m_flags[0]);
    hi = 0;
    r  = 0;
    z  = 0;
    n  = 0;
    sa = (x >= 128) ? x - 256 : x;
    sb = (y >= 128) ? y - 256 : y;
    case (op)
      0:  r = x;
      1:  r = y;
      2:  r = 255 - x;
      3:  r = 255 - y;
      4:  begin s = x + y;     ss = sa + sb;     r = s % 256; c = s / 256; o = int'(ss > 127 || ss < -128); end
      5:  begin s = x + y + c; ss = sa + sb + c; r = s % 256; c = s / 256; o = int'(ss > 127 || ss < -128); end
      6:  begin s = x + (255 - y) + 1; ss = sa - sb; r = s % 256; c = s / 256; o = int'(ss > 127 || ss < -128); end
      7:  r = x & y;
      8:  r = x | y;
      9:  r = x ^ y;
      10: begin r = (x * 2) % 256;        c = x / 128; end
      11: begin r = x / 2;                c = x % 2;   end
      12: begin r = x / 2 + (x / 128) * 128; c = x % 2; end
      13: begin r = (x * 2) % 256 + c;    c = x / 128; end
      14: begin r = x / 2 + c * 128;      c = x % 2;   end
      default: begin
        p  = x * y;
        r  = p % 256;
        hi = p / 256;
        c  = int'(hi != 0);
        o  = 0;
        z  = int'(p == 0);
        n  = p / 32768;
      end
    endcase
    if (op != 15) begin
      z = int'(r == 0);
      n = r / 128;
    end
    m_res   = r[7:0];
    m_hi    = hi[7:0];
    m_flags = {z[0], c[0], n[0], o[0]};
  endtask

  // Presents one request for a single edge; returns on the following falling edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start   = 1'b1;
    fun_sel = op;
    a       = x;
    b       = y;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    fun_sel = 4'h0;
    a       = 8'h00;
    b       = 8'h00;
    m_res   = 8'h00;
    m_hi    = 8'h00;
    m_flags = 4'h0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({result, result_hi, flags, busy, done} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state: got res=%h hi=%h flags=%b busy=%b done=%b, want all 0",
               result, result_hi, flags, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({result, result_hi, flags, busy, done} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got res=%h hi=%h flags=%b busy=%b done=%b, want all 0",
               result, result_hi, flags, busy, done);
    end
  endtask

  // Directed chain: each entry depends on the carry/overflow left by the previous one.
  task automatic test_directed();
    logic [3:0] ops  [7] = '{4'h4, 4'h6, 4'h5, 4'hD, 4'hE, 4'h4, 4'h7};
    logic [7:0] av   [7] = '{8'h7F, 8'h05, 8'h10, 8'h81, 8'h02, 8'h80, 8'hF0};
    logic [7:0] bv   [7] = '{8'h01, 8'h05, 8'h20, 8'h00, 8'h00, 8'h80, 8'h0F};
    logic [7:0] er   [7] = '{8'h80, 8'h00, 8'h31, 8'h02, 8'h81, 8'h00, 8'h00};
    logic [3:0] ef   [7] = '{4'b0011, 4'b1100, 4'b0000, 4'b0100, 4'b0010, 4'b1101, 4'b1101};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], av[i], bv[i]);
      model_op(int'(ops[i]), int'(av[i]), int'(bv[i]));
      n_tests++;
      if ({done, result_hi, result, flags} !== {1'b1, 8'h00, er[i], ef[i]}) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%h: got done=%b hi=%h res=%h flags=%b, want done=1 hi=00 res=%h flags=%b",
                 i, ops[i], done, result_hi, result, flags, er[i], ef[i]);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({done, result, flags} !== {1'b0, 8'h00, 4'b1101}) begin
      n_fail++;
      $display("FAIL hold_after_done: got done=%b res=%h flags=%b, want done=0 res=00 flags=1101",
               done, result, flags);
    end
  endtask

  task automatic test_random_alu();
    logic [3:0] op;
    logic [7:0] x, y;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 14));
      x  = 8'($urandom);
      y  = 8'($urandom);
      issue(op, x, y);
      model_op(int'(op), int'(x), int'(y));
      n_tests++;
      if ({done, busy, result_hi, result, flags} !== {1'b1, 1'b0, m_hi, m_res, m_flags}) begin
        n_fail++;
        $display("FAIL rand_alu[%0d] op=%h a=%h b=%h: got done=%b busy=%b hi=%h res=%h flags=%b, want 1/0/%h/%h/%b",
                 i, op, x, y, done, busy, result_hi, result, flags, m_hi, m_res, m_flags);
      end
    end
  endtask

  // Issues a MUL, disturbs inputs while busy, and checks latency and the single done pulse.
  task automatic test_mul(input logic [7:0] x, input logic [7:0] y, input string tag);
    int cyc;
    int early_done;
    issue(4'hF, x, y);
    model_op(15, int'(x), int'(y));
    cyc        = 0;
    early_done = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      if (done === 1'b1) early_done++;
      start   = cyc[0];
      fun_sel = 4'($urandom_range(0, 15));
      a       = 8'($urandom);
      b       = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (cyc != 8 || early_done != 0 ||
        {done, busy, result_hi, result, flags} !== {1'b1, 1'b0, m_hi, m_res, m_flags}) begin
      n_fail++;
      $display("FAIL mul_%s %h*%h: got busy_cycles=%0d early_done=%0d done=%b busy=%b hi=%h res=%h flags=%b, want 8/0/1/0/%h/%h/%b",
               tag, x, y, cyc, early_done, done, busy, result_hi, result, flags, m_hi, m_res, m_flags);
    end
  endtask

  task automatic test_mul_back_to_back();
    test_mul(8'hFF, 8'hFF, "ffxff");
    n_tests++;
    if ({result_hi, result, flags} !== {8'hFE, 8'h01, 4'b0110}) begin
      n_fail++;
      $display("FAIL mul_ffxff_const: got hi=%h res=%h flags=%b, want FE/01/0110", result_hi, result, flags);
    end
    // New ADD presented during the done cycle must be accepted.
    start   = 1'b1;
    fun_sel = 4'h4;
    a       = 8'h22;
    b       = 8'h11;
    model_op(4, 'h22, 'h11);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({done, busy, result_hi, result, flags} !== {1'b1, 1'b0, 8'h00, 8'h33, m_flags}) begin
      n_fail++;
      $display("FAIL add_in_done_cycle: got done=%b busy=%b hi=%h res=%h flags=%b, want 1/0/00/33/%b",
               done, busy, result_hi, result, flags, m_flags);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done_pulse: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_random_mul();
    for (int i = 0; i < 6; i++) begin
      test_mul(8'($urandom), 8'($urandom), "rand");
    end
    test_mul(8'h00, 8'h5A, "zero");
  endtask

  task automatic test_reset_mid_mul();
    issue(4'hF, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_busy: got busy=%b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({result, result_hi, flags, busy, done} !== 22'd0) begin
      n_fail++;
      $display("FAIL async_reset_mid_mul: got res=%h hi=%h flags=%b busy=%b done=%b, want all 0",
               result, result_hi, flags, busy, done);
    end
    m_res   = 8'h00;
    m_hi    = 8'h00;
    m_flags = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h4, 8'h01, 8'h01);
    model_op(4, 1, 1);
    n_tests++;
    if ({done, busy, result_hi, result, flags} !== {1'b1, 1'b0, 8'h00, 8'h02, m_flags}) begin
      n_fail++;
      $display("FAIL add_after_reset: got done=%b busy=%b hi=%h res=%h flags=%b, want 1/0/00/02/%b",
               done, busy, result_hi, result, flags, m_flags);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if ({done, busy, result} !== {1'b0, 1'b0, 8'h02}) begin
      n_fail++;
      $display("FAIL no_stale_mul: got done=%b busy=%b res=%h, want 0/0/02", done, busy, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_mul_back_to_back();
    test_random_mul();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
